// File: rtl/ring_phase_monitor_pkg.sv
// Shared types and helpers for the ring phase monitor.
package ring_phase_monitor_pkg;

    // Monitor FSM state; code 2'd3 is unused and recovers to ST_ACQUIRE.
    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    localparam int unsigned STATE_W = 2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of an index into an n-wide vector; never less than 1 bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ring_phase_monitor_onehot.sv
// Combinational one-hot to binary encoder with a one-hot qualifier.
module onehot_to_bin
    import ring_phase_monitor_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          onehot
);

    // OR of set-bit positions is the exact index whenever vec is one-hot.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = idx | IW'(i);
            end
        end
        onehot = (vec != '0) && ((vec & (vec - N'(1))) == '0);
    end

endmodule

// File: rtl/ring_phase_monitor.sv
// Health monitor and phase encoder for an N-bit one-hot ring counter.
module ring_phase_monitor
    import ring_phase_monitor_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned REV_W    = 8,
    parameter int unsigned ERR_W    = 4,
    localparam int unsigned IW      = idx_w(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     ring_i,
    input  logic             clear_i,
    output logic [IW-1:0]    phase_idx_o,
    output logic             phase_valid_o,
    output logic             locked_o,
    output logic             wrap_o,
    output logic [REV_W-1:0] rev_count_o,
    output logic             err_pulse_o,
    output logic [ERR_W-1:0] err_count_o
);

    localparam int unsigned AW = clog2(LOCK_CNT + 1);

    logic [N-1:0]  s_q;
    logic [N-1:0]  p_q;
    state_t        state;
    logic [AW-1:0] acq_cnt;

    logic [IW-1:0] enc_idx;
    logic          enc_onehot;
    logic [N-1:0]  rot_p;
    logic          step_ok;
    logic          wrap_hit;

    // Encoder on the current sample.
    onehot_to_bin #(.N(N)) u_enc (
        .vec    (s_q),
        .idx    (enc_idx),
        .onehot (enc_onehot)
    );

    // Expected successor of the previous sample and the per-cycle checks.
    always_comb begin
        rot_p    = {p_q[N-2:0], p_q[N-1]};
        step_ok  = enc_onehot && (s_q == rot_p);
        wrap_hit = s_q[0] && p_q[N-1];
    end

    // Two-stage sample pipeline of the ring vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_q <= '0;
            p_q <= '0;
        end else begin
            s_q <= ring_i;
            p_q <= s_q;
        end
    end

    // Phase index holds its last good value across invalid samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_idx_o   <= '0;
            phase_valid_o <= 1'b0;
        end else begin
            phase_valid_o <= enc_onehot;
            if (enc_onehot) begin
                phase_idx_o <= enc_idx;
            end
        end
    end

    // Lock FSM with revolution/error counters and their pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_ACQUIRE;
            acq_cnt     <= '0;
            locked_o    <= 1'b0;
            wrap_o      <= 1'b0;
            err_pulse_o <= 1'b0;
            rev_count_o <= '0;
            err_count_o <= '0;
        end else begin
            wrap_o      <= 1'b0;
            err_pulse_o <= 1'b0;

            case (state)
                ST_ACQUIRE: begin
                    if (acq_cnt == AW'(LOCK_CNT)) begin
                        state    <= ST_LOCKED;
                        acq_cnt  <= '0;
                        locked_o <= 1'b1;
                    end else begin
                        acq_cnt  <= step_ok ? (acq_cnt + AW'(1)) : '0;
                        locked_o <= 1'b0;
                    end
                end

                ST_LOCKED: begin
                    if (step_ok) begin
                        locked_o <= 1'b1;
                        if (wrap_hit) begin
                            wrap_o      <= 1'b1;
                            rev_count_o <= rev_count_o + REV_W'(1);
                        end
                    end else begin
                        state       <= ST_FAULT;
                        locked_o    <= 1'b0;
                        err_pulse_o <= 1'b1;
                        if (err_count_o != '1) begin
                            err_count_o <= err_count_o + ERR_W'(1);
                        end
                    end
                end

                ST_FAULT: begin
                    state    <= ST_ACQUIRE;
                    acq_cnt  <= '0;
                    locked_o <= 1'b0;
                end

                default: begin
                    state    <= ST_ACQUIRE;
                    acq_cnt  <= '0;
                    locked_o <= 1'b0;
                end
            endcase

            // Clear overrides any same-cycle increment; pulses are unaffected.
            if (clear_i) begin
                rev_count_o <= '0;
                err_count_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Self-checking bench for ring_phase_monitor with a behavioural reference model.
module tb_ring_phase_monitor;

    localparam int unsigned N        = 4;
    localparam int unsigned LOCK_CNT = 4;
    localparam int unsigned REV_W    = 8;
    localparam int unsigned ERR_W    = 4;
    localparam int unsigned IW       = $clog2(N);

    logic             clk = 1'b0;
    logic             reset;
    logic             clear_i;
    logic [N-1:0]     ring_i;
    logic [IW-1:0]    phase_idx_o;
    logic             phase_valid_o;
    logic             locked_o;
    logic             wrap_o;
    logic [REV_W-1:0] rev_count_o;
    logic             err_pulse_o;
    logic [ERR_W-1:0] err_count_o;

    always #5 clk = ~clk;

    ring_phase_monitor #(
        .N(N), .LOCK_CNT(LOCK_CNT), .REV_W(REV_W), .ERR_W(ERR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ring_i        (ring_i),
        .clear_i       (clear_i),
        .phase_idx_o   (phase_idx_o),
        .phase_valid_o (phase_valid_o),
        .locked_o      (locked_o),
        .wrap_o        (wrap_o),
        .rev_count_o   (rev_count_o),
        .err_pulse_o   (err_pulse_o),
        .err_count_o   (err_count_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: last two samples and health bookkeeping.
    logic [N-1:0] m_s, m_p;
    bit  m_locked, m_cooldown;
    int  m_run;
    int  e_idx, e_valid, e_locked, e_wrap, e_err, e_rev, e_errc;

    int ph;
    int wraps_seen, errs_seen, invalid_seen;

    function automatic int pos_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference model, using the samples held before the edge.
    task automatic model_edge(input logic [N-1:0] rin, input logic clr, input logic rst);
        bit oh, good;
        int si, pi;
        if (rst) begin
            m_s = '0; m_p = '0;
            m_locked = 0; m_cooldown = 0; m_run = 0;
            e_idx = 0; e_valid = 0; e_locked = 0; e_wrap = 0; e_err = 0;
            e_rev = 0; e_errc = 0;
            return;
        end
        oh   = ($countones(m_s) == 1);
        si   = pos_of(m_s);
        pi   = pos_of(m_p);
        good = oh && ($countones(m_p) == 1) && (si == (pi + 1) % N);
        e_valid = oh ? 1 : 0;
        if (oh) e_idx = si;
        e_wrap = 0;
        e_err  = 0;
        if (m_cooldown) begin
            m_cooldown = 0;
            m_run = 0;
        end else if (m_locked) begin
            if (good) begin
                if (si == 0 && pi == N - 1) begin
                    e_wrap = 1;
                    e_rev  = (e_rev + 1) % (1 << REV_W);
                end
            end else begin
                m_locked   = 0;
                m_cooldown = 1;
                e_err      = 1;
                if (e_errc < (1 << ERR_W) - 1) e_errc++;
            end
        end else begin
            if (m_run == LOCK_CNT) begin
                m_locked = 1;
                m_run = 0;
            end else begin
                m_run = good ? m_run + 1 : 0;
            end
        end
        if (clr) begin
            e_rev = 0;
            e_errc = 0;
        end
        e_locked = m_locked ? 1 : 0;
        m_p = m_s;
        m_s = rin;
    endtask

    // Drive one cycle, advance the model, then compare every output.
    task automatic step(input logic [N-1:0] rin, input logic clr, input logic rst);
        ring_i  = rin;
        clear_i = clr;
        reset   = rst;
        @(posedge clk);
        model_edge(rin, clr, rst);
        #1;
        chk("phase_idx",   32'(phase_idx_o),   32'(e_idx));
        chk("phase_valid", 32'(phase_valid_o), 32'(e_valid));
        chk("locked",      32'(locked_o),      32'(e_locked));
        chk("wrap",        32'(wrap_o),        32'(e_wrap));
        chk("rev_count",   32'(rev_count_o),   32'(e_rev));
        chk("err_pulse",   32'(err_pulse_o),   32'(e_err));
        chk("err_count",   32'(err_count_o),   32'(e_errc));
        if (wrap_o === 1'b1)        wraps_seen++;
        if (err_pulse_o === 1'b1)   errs_seen++;
        if (phase_valid_o === 1'b0) invalid_seen++;
        reset   = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic good(input int n);
        logic [N-1:0] v;
        for (int k = 0; k < n; k++) begin
            v = 1;
            v = v << ph;
            step(v, 1'b0, 1'b0);
            ph = (ph + 1) % N;
        end
    endtask

    initial begin
        logic [N-1:0] v;
        logic [N-1:0] two_hot;
        int r;

        reset = 1'b1; clear_i = 1'b0; ring_i = '0;
        ph = 0; wraps_seen = 0; errs_seen = 0; invalid_seen = 0;

        // Reset state
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        chk("rst_locked", 32'(locked_o), 32'd0);
        chk("rst_valid",  32'(phase_valid_o), 32'd0);

        // Acquire: lock timing and 2-cycle phase lag
        for (int i = 0; i < 7; i++) begin
            good(1);
            if (i >= 1) chk("s1_idx", 32'(phase_idx_o), 32'((i - 1) % N));
            if (i == 5) chk("s1_not_locked", 32'(locked_o), 32'd0);
            if (i == 6) chk("s1_locked", 32'(locked_o), 32'd1);
        end

        // Ten revolutions while locked
        wraps_seen = 0;
        good(40);
        chk("s2_wraps", 32'(wraps_seen), 32'd10);
        chk("s2_rev",   32'(rev_count_o), 32'd10);
        chk("s2_err",   32'(err_count_o), 32'd0);

        // Two-hot glitch for one cycle, then relock
        errs_seen = 0; invalid_seen = 0;
        v = 4'b0101;
        step(v, 1'b0, 1'b0);
        ph = (ph + 1) % N;
        good(12);
        chk("s3_errs",    32'(errs_seen),    32'd1);
        chk("s3_invalid", 32'(invalid_seen), 32'd1);
        chk("s3_errcnt",  32'(err_count_o),  32'd1);
        chk("s3_relock",  32'(locked_o),     32'd1);

        // Skipped position 0010 -> 1000
        while (ph != 1) good(1);
        v = 4'b0010; step(v, 1'b0, 1'b0);
        v = 4'b1000; step(v, 1'b0, 1'b0);
        ph = 0;
        good(1);
        chk("s4_err_pulse", 32'(err_pulse_o),   32'd1);
        chk("s4_valid",     32'(phase_valid_o), 32'd1);
        chk("s4_idx",       32'(phase_idx_o),   32'd3);
        chk("s4_errcnt",    32'(err_count_o),   32'd2);

        // Twenty random faults: saturation
        two_hot = 4'b0011;
        for (int f = 0; f < 20; f++) begin
            good(9);
            r = $urandom_range(0, 2);
            if (r == 0) begin
                v = '0;
            end else if (r == 1) begin
                v = N'($urandom);
                if ($countones(v) < 2) v = two_hot;
            end else begin
                v = 1;
                v = v << ((ph + N - 1) % N);
            end
            step(v, 1'b0, 1'b0);
            ph = (ph + 1) % N;
        end
        good(9);
        chk("s5_sat", 32'(err_count_o), 32'd15);

        // Clear coinciding with a wrap
        while (ph != 0) good(1);
        good(1);
        v = 1;
        v = v << ph;
        step(v, 1'b1, 1'b0);
        ph = (ph + 1) % N;
        chk("s5_clr_wrap", 32'(wrap_o),      32'd1);
        chk("s5_clr_rev",  32'(rev_count_o), 32'd0);
        chk("s5_clr_err",  32'(err_count_o), 32'd0);

        // Reset while locked at rev_count = 5 (bounded wait)
        for (int k = 0; k < 64 && rev_count_o !== REV_W'(5); k++) good(1);
        chk("s6_rev5",   32'(rev_count_o), 32'd5);
        chk("s6_locked", 32'(locked_o),    32'd1);
        v = 1;
        v = v << ph;
        step(v, 1'b0, 1'b1);
        chk("s6_rst_idx",    32'(phase_idx_o),   32'd0);
        chk("s6_rst_valid",  32'(phase_valid_o), 32'd0);
        chk("s6_rst_locked", 32'(locked_o),      32'd0);
        chk("s6_rst_wrap",   32'(wrap_o),        32'd0);
        chk("s6_rst_rev",    32'(rev_count_o),   32'd0);
        chk("s6_rst_pulse",  32'(err_pulse_o),   32'd0);
        chk("s6_rst_err",    32'(err_count_o),   32'd0);
        ph = 0;
        for (int i = 0; i < 7; i++) begin
            good(1);
            if (i == 5) chk("s6_not_locked", 32'(locked_o), 32'd0);
            if (i == 6) chk("s6_relocked",   32'(locked_o), 32'd1);
        end

        // Random soak: mostly good steps, occasional garbage and clears
        for (int c = 0; c < 300; c++) begin
            r = $urandom_range(0, 99);
            if (r >= 90) begin
                v = N'($urandom);
            end else begin
                v = 1;
                v = v << ph;
            end
            step(v, (r < 5) ? 1'b1 : 1'b0, 1'b0);
            ph = (ph + 1) % N;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
